// File: rtl/tetron_collision_checker_pkg.sv
// Shared constants, coordinate type and checker state encoding for the
// tetron collision checker and its bench.
package tetron_collision_checker_pkg;

   localparam int BOARD_W = 10;
   localparam int BOARD_H = 20;
   localparam int CW      = 5;

   typedef logic [CW-1:0] coord_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } chk_state_t;

endpackage

// File: rtl/tetron_collision_checker_cell_locator.sv
// Combinational block locator: origin + signed offset (mod 2^CW) and a
// playfield bounds test. Negative results wrap high and land out of bounds.
module tetron_cell_locator #(
   parameter int BOARD_W = tetron_collision_checker_pkg::BOARD_W,
   parameter int BOARD_H = tetron_collision_checker_pkg::BOARD_H,
   parameter int CW      = tetron_collision_checker_pkg::CW
) (
   input  logic [CW-1:0] origin_row,
   input  logic [CW-1:0] origin_col,
   input  logic [CW-1:0] voffset,
   input  logic [CW-1:0] hoffset,
   output logic [CW-1:0] row,
   output logic [CW-1:0] col,
   output logic          out_of_bounds
);
   import tetron_collision_checker_pkg::*;

   localparam logic [CW-1:0] ROW_LIM = CW'(BOARD_H);
   localparam logic [CW-1:0] COL_LIM = CW'(BOARD_W);

   assign row = origin_row + voffset;
   assign col = origin_col + hoffset;
   assign out_of_bounds = (row >= ROW_LIM) || (col >= COL_LIM);

endmodule

// File: rtl/tetron_collision_checker.sv
// Checks whether a four-block tetron fits the playfield: bounds test per
// block plus one board read per in-bounds block, verdict at fixed latency.
//
// state | meaning
// IDLE  | waiting for start; verdict from the last check held on collide
// SCAN  | one block per cycle (idx 0..3): read its cell or flag it out of bounds
// DRAIN | collect the read data for the last block
// DONE  | done pulse; collide carries the sticky verdict
module tetron_collision_checker #(
   parameter int BOARD_W = tetron_collision_checker_pkg::BOARD_W,
   parameter int BOARD_H = tetron_collision_checker_pkg::BOARD_H,
   parameter int CW      = tetron_collision_checker_pkg::CW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [CW-1:0] origin_row,
   input  logic [CW-1:0] origin_col,
   input  logic [CW-1:0] blk1_voffset,
   input  logic [CW-1:0] blk2_voffset,
   input  logic [CW-1:0] blk3_voffset,
   input  logic [CW-1:0] blk4_voffset,
   input  logic [CW-1:0] blk1_hoffset,
   input  logic [CW-1:0] blk2_hoffset,
   input  logic [CW-1:0] blk3_hoffset,
   input  logic [CW-1:0] blk4_hoffset,
   output logic          board_rd_en,
   output logic [CW-1:0] board_rd_row,
   output logic [CW-1:0] board_rd_col,
   input  logic          board_rd_data,
   output logic          busy,
   output logic          done,
   output logic          collide
);
   import tetron_collision_checker_pkg::*;

   chk_state_t    state, state_nxt;
   logic [1:0]    idx;
   logic [CW-1:0] org_row, org_col;
   logic [CW-1:0] voff [4];
   logic [CW-1:0] hoff [4];
   logic [CW-1:0] last_row, last_col;
   logic [CW-1:0] cur_row, cur_col;
   logic          cur_oob;
   logic          sticky, rd_pend, collide_q;
   logic          accept, scan_en, hit;

   assign accept = start && (state == IDLE);
   // Read data is only meaningful in the cycle right after a strobe.
   assign hit    = rd_pend && board_rd_data;

   tetron_cell_locator #(
      .BOARD_W (BOARD_W),
      .BOARD_H (BOARD_H),
      .CW      (CW)
   ) u_locator (
      .origin_row    (org_row),
      .origin_col    (org_col),
      .voffset       (voff[idx]),
      .hoffset       (hoff[idx]),
      .row           (cur_row),
      .col           (cur_col),
      .out_of_bounds (cur_oob)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      scan_en   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = SCAN;
         end
         SCAN: begin
            busy    = 1'b1;
            scan_en = !cur_oob;
            if (idx == 2'd3) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= 2'd0;
         org_row   <= '0;
         org_col   <= '0;
         for (int i = 0; i < 4; i++) begin
            voff[i] <= '0;
            hoff[i] <= '0;
         end
         sticky    <= 1'b0;
         rd_pend   <= 1'b0;
         collide_q <= 1'b0;
         last_row  <= '0;
         last_col  <= '0;
      end else begin
         rd_pend <= scan_en;
         if (accept) begin
            idx       <= 2'd0;
            org_row   <= origin_row;
            org_col   <= origin_col;
            voff[0]   <= blk1_voffset;
            voff[1]   <= blk2_voffset;
            voff[2]   <= blk3_voffset;
            voff[3]   <= blk4_voffset;
            hoff[0]   <= blk1_hoffset;
            hoff[1]   <= blk2_hoffset;
            hoff[2]   <= blk3_hoffset;
            hoff[3]   <= blk4_hoffset;
            sticky    <= 1'b0;
            collide_q <= 1'b0;
         end else begin
            if (state == SCAN) begin
               idx <= idx + 2'd1;
               if (cur_oob) sticky <= 1'b1;
            end
            if (hit) sticky <= 1'b1;
            // The last block's read data arrives during DRAIN, so fold it in here.
            if (state == DRAIN) collide_q <= sticky | hit;
         end
         if (scan_en) begin
            last_row <= cur_row;
            last_col <= cur_col;
         end
      end
   end

   assign board_rd_en  = scan_en;
   assign board_rd_row = scan_en ? cur_row : last_row;
   assign board_rd_col = scan_en ? cur_col : last_col;
   assign collide      = collide_q;

endmodule

// File: doc/tetron_collision_checker.md
Name: tetron_collision_checker

Overview:
- Consumes the four (voffset, hoffset) block offsets produced by the per-shape tetron shaper stage, adds them to the falling piece's origin, and decides whether the piece fits the playfield.
- Reads the locked-block board memory one cell per cycle and reports a single collide/fit verdict with fixed latency.
- Sits between the shaper stage and the game-control FSM, which uses the verdict to accept or reject a move, rotation or spawn.

Parameters:
- BOARD_W, 10, playfield columns; legal col = 0..BOARD_W-1
- BOARD_H, 20, playfield rows; legal row = 0..BOARD_H-1
- CW, 5, width of row/col coordinates and offsets

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request check; accepted only when busy=0
- origin_row  in  CW  piece origin row, unsigned
- origin_col  in  CW  piece origin col, unsigned
- blk1_voffset..blk4_voffset  in  CW each  row offsets, two's complement
- blk1_hoffset..blk4_hoffset  in  CW each  col offsets, two's complement
- board_rd_en  out  1  board read strobe
- board_rd_row  out  CW  board read row
- board_rd_col  out  CW  board read col
- board_rd_data  in  1  cell occupied; valid exactly 1 cycle after board_rd_en
- busy  out  1  check in progress
- done  out  1  one-cycle pulse; verdict valid
- collide  out  1  1 = piece does not fit; held until next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, collide=0, board_rd_en=0, board_rd_row=0, board_rd_col=0.
- Acceptance: start=1 and state=IDLE at a rising edge (cycle T).
  - Origin and all 8 offsets are captured into registers at that edge.
  - Later input changes do not affect the check in progress.
  - collide clears to 0 at that edge.
- Input timing: the shaper output is registered, so the requester holds the rotation stable one cycle before asserting start.
- Position arithmetic: row_i = origin_row + voffset_i and col_i = origin_col + hoffset_i, both mod 2^CW (plain CW-bit add, carry dropped).
- Out-of-bounds rule: row_i >= BOARD_H or col_i >= BOARD_W.
  - Negative results wrap to 31..27 and are therefore out of bounds.
  - An out-of-bounds block counts as a collision.
- States:
  - IDLE: busy=0. On accept → SCAN, idx=0.
  - SCAN: busy=1, 4 cycles (T+1..T+4), idx 0..3 = blk1..blk4.
    - In-bounds block: board_rd_en=1, rd_row/rd_col = row_i/col_i.
    - Out-of-bounds block: board_rd_en=0, sticky collision flag set.
    - After idx=3 → DRAIN.
  - DRAIN: busy=1, 1 cycle (T+5). Receives the read data for idx=3.
  - DONE: busy=1 and done=1 for 1 cycle (T+6); collide = sticky flag. Then → IDLE.
- Read data: in every cycle following a board_rd_en=1 cycle, board_rd_data=1 sets the sticky flag. Data in other cycles is ignored.
- No early exit: latency is always start edge T to done at T+6, regardless of when a collision is found.
- Back-to-back: start may be reasserted in the cycle after DONE, when state is IDLE.
- start while busy=1: ignored, with no queueing.
- board_rd_row/board_rd_col hold their last value when board_rd_en=0.
- Duplicate block positions are not checked; they produce a redundant read only.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. No done pulse is emitted.

Decomposition:
- Shared tetris package:
  - BOARD_W, BOARD_H, CW constants
  - a coord typedef (CW-bit)
  - the checker state enum (IDLE, SCAN, DRAIN, DONE)
- One sub-module: tetron_cell_locator. It is purely combinational; it adds origin and offset and produces row, col and an out_of_bounds flag. It is instantiated once and muxed by idx.

Test Plan:
- Empty board, origin (5,4), offsets (0,0)(-1,0)(0,-1)(1,-1):
  - reads at (5,4)(4,4)(5,3)(6,3) on T+1..T+4
  - done=1 only at T+6, collide=0
- Same piece, cell (6,3) occupied in the board model → done at T+6, collide=1.
- Origin (5,0), hoffset -1 on blk3 (col wraps to 31):
  - exactly 3 board_rd_en pulses
  - collide=1, done still at T+6
- Origin (19,4), voffset +1 on blk4 → row 20 out of bounds → collide=1.
- start held high through the check with different origin values:
  - only the first request is processed
  - a second check begins only after DONE, with the origin values present at that accepting edge
- rst_n low during SCAN cycle T+2:
  - busy/board_rd_en drop immediately
  - no done pulse
  - a new start after release completes normally at T'+6
